// File: rtl/muntjac_fetch_queue.sv
// In-order fetch queue: reserves a slot per cache request, pairs responses
// with PC/reason metadata, and drops stale responses after a redirect flush.
package muntjac_fetch_pkg;
  typedef enum logic [1:0] {
    IF_PREFETCH,
    IF_PREDICT,
    IF_MISPREDICT,
    IF_ROLLBACK
  } if_reason_e;

  typedef enum logic [4:0] {
    EXC_CAUSE_INSTR_ACCESS_FAULT = 5'd1,
    EXC_CAUSE_INSTR_PAGE_FAULT   = 5'd12
  } exc_cause_e;

  typedef struct packed {
    exc_cause_e  cause;
    logic [63:0] tval;
  } exception_t;

  typedef struct packed {
    logic [31:0] instr_word;
    logic [63:0] pc;
    if_reason_e  if_reason;
    logic        ex_valid;
    exception_t  exception;
  } fetched_instr_t;
endpackage

module muntjac_fetch_queue
  import muntjac_fetch_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [XLEN-1:0]            issue_pc_i,
  input  if_reason_e                 issue_reason_i,
  input  logic                       resp_valid_i,
  input  logic [31:0]                resp_instr_i,
  input  logic                       resp_exception_i,
  input  logic                       resp_exception_plus2_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output fetched_instr_t             out_instr_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned DW = $clog2(MAX_INFLIGHT + 1);

  logic [PW-1:0] head_q, fill_q, alloc_q;
  logic [DW-1:0] discard_q;

  logic [XLEN-1:0] pc_q     [DEPTH];
  if_reason_e      reason_q [DEPTH];
  logic [31:0]     instr_q  [DEPTH];
  logic [DEPTH-1:0] ex_q, ex2_q;

  logic [PW-1:0] inflight, occ;
  logic [PW:0]   used, stale_sum;
  logic          issue_fire, fill_en, drop, pop;

  assign inflight = alloc_q - fill_q;
  assign occ      = alloc_q - head_q;
  assign used     = {1'b0, inflight} + (PW+1)'(discard_q);

  assign issue_ready_o = !flush_i
                      && occ < PW'(DEPTH)
                      && used < (PW+1)'(MAX_INFLIGHT);
  assign occupancy_o = OW'(occ);

  assign issue_fire = issue_valid_i && issue_ready_o;
  assign drop       = !flush_i && resp_valid_i && discard_q != '0;
  assign fill_en    = !flush_i && resp_valid_i && discard_q == '0
                   && inflight != '0;
  assign out_valid_o = head_q != fill_q;
  assign pop        = !flush_i && out_valid_o && out_ready_i;

  // Everything outstanding goes stale; a response this cycle is one of them.
  assign stale_sum = used - (PW+1)'(resp_valid_i && used != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q    <= '0;
      fill_q    <= '0;
      alloc_q   <= '0;
      discard_q <= '0;
    end else if (flush_i) begin
      head_q    <= '0;
      fill_q    <= '0;
      alloc_q   <= '0;
      discard_q <= DW'(stale_sum);
    end else begin
      if (issue_fire) alloc_q   <= alloc_q + 1'b1;
      if (fill_en)    fill_q    <= fill_q + 1'b1;
      if (pop)        head_q    <= head_q + 1'b1;
      if (drop)       discard_q <= discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue_fire) begin
      pc_q[alloc_q[AW-1:0]]     <= issue_pc_i;
      reason_q[alloc_q[AW-1:0]] <= issue_reason_i;
    end
    if (fill_en) begin
      instr_q[fill_q[AW-1:0]] <= resp_instr_i;
      ex_q[fill_q[AW-1:0]]    <= resp_exception_i;
      ex2_q[fill_q[AW-1:0]]   <= resp_exception_plus2_i;
    end
  end

  logic [AW-1:0]   hidx;
  logic [XLEN-1:0] hpc, tval;

  assign hidx = head_q[AW-1:0];
  assign hpc  = pc_q[hidx];
  assign tval = ex2_q[hidx] ? {hpc[XLEN-1:2], 2'b00} + XLEN'(4) : hpc;

  always_comb begin
    out_instr_o                 = '0;
    out_instr_o.instr_word      = instr_q[hidx];
    out_instr_o.pc              = 64'(hpc);
    out_instr_o.if_reason       = reason_q[hidx];
    out_instr_o.ex_valid        = ex_q[hidx];
    out_instr_o.exception.cause = EXC_CAUSE_INSTR_PAGE_FAULT;
    out_instr_o.exception.tval  = 64'(tval);
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && resp_valid_i)
      assert (discard_q != '0 || inflight != '0);
  end
`endif

endmodule

// File: tb/tb_muntjac_fetch_queue.sv
// Bench for muntjac_fetch_queue: queue-based reference model plus
// directed scenarios and a randomized phase.
module tb_muntjac_fetch_queue;
  import muntjac_fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int MI    = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic flush_i;
  logic issue_valid_i;
  logic issue_ready_o;
  logic [63:0] issue_pc_i;
  if_reason_e issue_reason_i;
  logic resp_valid_i;
  logic [31:0] resp_instr_i;
  logic resp_exception_i;
  logic resp_exception_plus2_i;
  logic out_valid_o;
  logic out_ready_i;
  fetched_instr_t out_instr_o;
  logic [$clog2(DEPTH+1)-1:0] occupancy_o;

  muntjac_fetch_queue #(
    .XLEN(64), .DEPTH(DEPTH), .MAX_INFLIGHT(MI)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush_i(flush_i),
    .issue_valid_i(issue_valid_i),
    .issue_ready_o(issue_ready_o),
    .issue_pc_i(issue_pc_i),
    .issue_reason_i(issue_reason_i),
    .resp_valid_i(resp_valid_i),
    .resp_instr_i(resp_instr_i),
    .resp_exception_i(resp_exception_i),
    .resp_exception_plus2_i(resp_exception_plus2_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_instr_o(out_instr_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] pc;
    if_reason_e  r;
    logic [31:0] instr;
    logic        ex;
    logic        ex2;
  } ent_t;

  ent_t filled[$];
  ent_t pending[$];
  int   discard;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] next_pc;

  task automatic check(string nm, logic [255:0] got, logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic fetched_instr_t head_exp();
    fetched_instr_t f;
    ent_t e;
    e = filled[0];
    f = '0;
    f.instr_word      = e.instr;
    f.pc              = e.pc;
    f.if_reason       = e.r;
    f.ex_valid        = e.ex;
    f.exception.cause = EXC_CAUSE_INSTR_PAGE_FAULT;
    f.exception.tval  = e.ex2 ? ((e.pc & ~64'd3) + 64'd4) : e.pc;
    return f;
  endfunction

  // Compare against the model, then advance the model by one clock edge.
  task automatic model_step();
    bit   rdy, popf;
    int   d;
    ent_t e;
    rdy = !flush_i && (filled.size() + pending.size()) < DEPTH
        && (pending.size() + discard) < MI;
    check("issue_ready", issue_ready_o, rdy);
    check("out_valid", out_valid_o, filled.size() > 0);
    check("occupancy", occupancy_o, filled.size() + pending.size());
    if (filled.size() > 0) check("out_instr", out_instr_o, head_exp());
    if (flush_i) begin
      d = discard + pending.size() - (resp_valid_i ? 1 : 0);
      discard = (d < 0) ? 0 : d;
      filled.delete();
      pending.delete();
    end else begin
      popf = filled.size() > 0 && out_ready_i;
      if (popf) void'(filled.pop_front());
      if (resp_valid_i) begin
        if (discard > 0) discard--;
        else if (pending.size() > 0) begin
          e = pending.pop_front();
          e.instr = resp_instr_i;
          e.ex    = resp_exception_i;
          e.ex2   = resp_exception_plus2_i;
          filled.push_back(e);
        end
      end
      if (rdy && issue_valid_i) begin
        e.pc = issue_pc_i;
        e.r  = issue_reason_i;
        e.instr = '0;
        e.ex = 1'b0;
        e.ex2 = 1'b0;
        pending.push_back(e);
      end
    end
  endtask

  task automatic idle();
    flush_i = 0;
    issue_valid_i = 0;
    issue_pc_i = '0;
    issue_reason_i = IF_PREFETCH;
    resp_valid_i = 0;
    resp_instr_i = '0;
    resp_exception_i = 0;
    resp_exception_plus2_i = 0;
    out_ready_i = 0;
  endtask

  task automatic cyc(input bit iv, input logic [63:0] pc, input bit rv,
                     input bit ex, input bit ex2, input bit ordy,
                     input bit fl);
    issue_valid_i = iv;
    issue_pc_i = pc;
    issue_reason_i = if_reason_e'($urandom_range(0, 3));
    resp_valid_i = rv;
    resp_instr_i = $urandom;
    resp_exception_i = ex;
    resp_exception_plus2_i = ex2;
    out_ready_i = ordy;
    flush_i = fl;
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  initial begin
    idle();
    discard = 0;
    rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    check("rst_valid", out_valid_o, 0);
    check("rst_occ", occupancy_o, 0);
    check("rst_ready", issue_ready_o, 1);

    // back-to-back fill with decode stalled
    cyc(1, 64'h0, 0, 0, 0, 0, 0);
    cyc(1, 64'h4, 0, 0, 0, 0, 0);
    check("credit_full_ready", issue_ready_o, 0);
    check("credit_full_occ", occupancy_o, 2);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("credit_back_ready", issue_ready_o, 1);
    cyc(1, 64'h8, 1, 0, 0, 0, 0);
    cyc(1, 64'hC, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("full_occ", occupancy_o, 4);
    check("full_ready", issue_ready_o, 0);
    check("full_head_pc", out_instr_o.pc, 64'h0);
    repeat (3) cyc(1, 64'h80, 0, 0, 0, 0, 0);
    check("stall_head_pc", out_instr_o.pc, 64'h0);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", out_instr_o.pc, 64'(i * 4));
      check("drain_occ", occupancy_o, 4 - i);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    check("drained_valid", out_valid_o, 0);

    // flush with two in flight
    cyc(1, 64'h40, 0, 0, 0, 0, 0);
    cyc(1, 64'h44, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    check("post_flush_valid", out_valid_o, 0);
    check("post_flush_ready", issue_ready_o, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    check("stale_dropped", out_valid_o, 0);
    cyc(1, 64'h100, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("after_flush_pc", out_instr_o.pc, 64'h100);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // flush coincident with a response
    cyc(1, 64'h200, 0, 0, 0, 0, 0);
    cyc(1, 64'h204, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("coinc_dropped", out_valid_o, 0);
    cyc(1, 64'h300, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("coinc_fill_pc", out_instr_o.pc, 64'h300);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // page fault tval
    cyc(1, 64'h1002, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0);
    check("pf_ex", out_instr_o.ex_valid, 1);
    check("pf_tval_plus2", out_instr_o.exception.tval, 64'h1004);
    check("pf_cause", out_instr_o.exception.cause,
          EXC_CAUSE_INSTR_PAGE_FAULT);
    cyc(1, 64'h1002, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    check("pf_tval", out_instr_o.exception.tval, 64'h1002);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // randomized traffic with wrap-around and occasional flushes
    next_pc = 64'h8000;
    for (int i = 0; i < 600; i++) begin
      bit iv, rv, fl;
      iv = $urandom_range(0, 3) != 0;
      rv = (pending.size() + discard) > 0 && $urandom_range(0, 9) < 6;
      fl = $urandom_range(0, 39) == 0;
      cyc(iv, next_pc, rv, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, fl);
      next_pc += 64'd4;
    end

    // reset mid-operation
    cyc(1, 64'h500, 0, 0, 0, 0, 0);
    cyc(1, 64'h504, 0, 0, 0, 0, 0);
    rst_ni = 0;
    #1;
    check("midrst_occ", occupancy_o, 0);
    check("midrst_valid", out_valid_o, 0);
    filled.delete();
    pending.delete();
    discard = 0;
    @(posedge clk_i);
    #1 rst_ni = 1;
    cyc(1, 64'h600, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("midrst_pc", out_instr_o.pc, 64'h600);
    cyc(0, 0, 0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muntjac_fetch_queue.md
# muntjac_fetch_queue

Parametrised in-order instruction fetch queue between the fetch request logic and decode. It reserves a slot per issued instruction-cache request. It pairs each in-order response with its PC/reason metadata, and buffers up to `DEPTH` fetched instructions with `MAX_INFLIGHT` outstanding requests. On a redirect flush it discards buffered entries and silently drops stale in-flight responses. It replaces the single-entry response latch with multi-entry buffering and multiple outstanding requests.

## Interface

Parameters:
- `XLEN`, 64, address width.
- `DEPTH`, 4, queue slots; power of two, ≥2.
- `MAX_INFLIGHT`, 2, maximum outstanding cache requests, including stale ones; 1..`DEPTH`.

Ports:
- `clk_i`  in  1  clock; the block uses one clock, all state on its rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  discard all buffered and in-flight entries this cycle.
- `issue_valid_i`  in  1  upstream sends a cache request this cycle.
- `issue_ready_o`  out  1  a slot and an in-flight credit are available.
- `issue_pc_i`  in  XLEN  PC of the issued request.
- `issue_reason_i`  in  `if_reason_e`  reason of the issued request.
- `resp_valid_i`  in  1  cache response; in order; cannot be back-pressured.
- `resp_instr_i`  in  32  instruction word.
- `resp_exception_i`  in  1  fetch page fault.
- `resp_exception_plus2_i`  in  1  fault is on the second halfword.
- `out_valid_o`  out  1  head entry is filled.
- `out_ready_i`  in  1  decode accepts the head.
- `out_instr_o`  out  `fetched_instr_t`  head entry.
- `occupancy_o`  out  $clog2(DEPTH+1)  reserved slot count (filled plus awaiting response).

## Operation

Storage and pointers:
- Storage is `DEPTH` entries of {pc, reason, instr, ex, ex_plus2}.
- Pointers `head`, `fill` and `alloc` are each $clog2(DEPTH)+1 bits. The MSB is the wrap bit, and pointers wrap modulo 2·`DEPTH`.
- `inflight = alloc − fill` (modulo arithmetic).
- `occupancy_o = alloc − head`.
- Invariant: head ≤ fill ≤ alloc in ring order.

Issue:
- `issue_ready_o = !flush_i && occupancy_o < DEPTH && (inflight + discard) < MAX_INFLIGHT`.
- An issue fires when `issue_valid_i && issue_ready_o`. It writes pc and reason into entry `alloc`, then `alloc++`.

Response:
- If `discard ≠ 0`, the response is dropped and `discard` decrements.
- Otherwise, if `inflight ≠ 0`, instr/ex/ex_plus2 are written into entry `fill`, then `fill++`.
- Otherwise the response is a protocol error: it is ignored and an assertion fires.

Output:
- `out_valid_o = (head ≠ fill)`.
- A pop fires on `out_valid_o && out_ready_i`, then `head++`.
- `out_instr_o` fields:
  - `instr_word`, `pc` and `if_reason` come from the head entry.
  - `ex_valid` is the head entry's ex bit.
  - `exception.cause` is always `EXC_CAUSE_INSTR_PAGE_FAULT`.
  - `exception.tval` is `{pc[XLEN-1:2],2'b0}+4` if ex_plus2, else pc.

Flush (highest priority):
- `head`, `fill` and `alloc` go to 0.
- `discard` becomes `discard + inflight − (resp_valid_i ? 1 : 0)`. A response in the flush cycle counts as stale, and the result saturates at 0.
- Pops and issues in the flush cycle have no effect. `issue_ready_o` is already low.

Simultaneous events without flush:
- Issue, response and pop may all fire in one cycle, each updating its own pointer.
- A pop never consumes an entry filled in the same cycle.

Counter width:
- `discard` is $clog2(MAX_INFLIGHT+1) bits.
- `inflight + discard ≤ MAX_INFLIGHT` always holds.

## Timing

Reset state:
- `out_valid_o`=0, `occupancy_o`=0, `issue_ready_o`=1 (with `flush_i` low).
- Pointers and `discard` are 0, and storage contents are don't-care.
- Reset mid-operation abandons all state. Responses arriving after reset with `inflight`=0 are protocol errors.

Latency and throughput:
- Response to `out_valid_o`: 1 cycle. A response at cycle N is visible at N+1; there is no bypass.
- Issue to slot reservation: same edge. `issue_ready_o` reflects the new state the next cycle.
- Sustained throughput is one instruction per cycle when `DEPTH ≥ MAX_INFLIGHT + 1` and the response latency is 1.

Output rules:
- The output is stable while `out_valid_o && !out_ready_i`.
- `out_valid_o` is 0 in the cycle after a flush.

## Test plan

- **Back-to-back fill:** reset, issue 4 requests at pc 0x0, 0x4, 0x8, 0xC with 1-cycle responses and `out_ready_i`=0 → `occupancy_o` rises to 4. `issue_ready_o` drops after the 2nd issue (MAX_INFLIGHT=2) until a response lands, then again when full. Draining outputs the pcs in order.
- **Stalled decode:** hold `out_ready_i`=0 with the queue full → `issue_ready_o`=0 and `out_instr_o` is stable. Release → one pop per cycle and `occupancy_o` decrements 4→0.
- **Flush with 2 in flight:** assert `flush_i` with both responses still outstanding → the next 2 responses are dropped, `out_valid_o` stays 0, and a new issue at pc 0x100 after the flush is the first instruction output.
- **Flush coincident with response:** 2 in flight, flush in the same cycle as one response → only 1 further response is dropped, and the next one fills.
- **Page fault tval:** response with ex=1, plus2=1 at pc 0x1002 → `tval`=0x1004 and cause=page fault. With plus2=0 → `tval`=0x1002.
- **Wrap-around:** run 3·DEPTH+1 issues and pops with random `out_ready_i` → no loss or duplication, and the pc sequence matches the issue order.
